usb_tx_seq: RTL and testbench

Parametrised USB transmit sequencer: accepts a payload byte stream over a valid/ready input port and emits it on a valid/ready transmit port. When compiled in, it appends the USB CRC16 as two trailing bytes. It also keeps a configurable-depth history of accepted transmit beats for observability. It sits between the packet builder and the PHY-side transmit interface and replaces the fixed three-state CRC test sequencer.

---
 rtl/usb_tx_pkg.sv | 16 +
 rtl/usb_crc16_byte.sv | 28 ++
 rtl/usb_tx_seq.sv | 177 +++++++++++++++++
 tb/tb_usb_tx_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the USB transmit sequencer.
// The CRC-related constants are only consumed when USB_TX_CRC_EN is defined.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      CRC1,
      CRC2,
      DRAIN
   } state_e;

   localparam logic [15:0] CRC_POLY = 16'hA001;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/usb_crc16_byte.sv
// usb_crc16_byte: combinational USB CRC16 update for one byte, LSB first,
// using the reflected polynomial. Only built when USB_TX_CRC_EN is defined.
`ifdef USB_TX_CRC_EN
module usb_crc16_byte
   import usb_tx_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);

   logic [15:0] crc_v;

   // Fold the byte into the low half, then shift out eight bits one at a time
   always_comb begin
      crc_v = crc_in ^ {8'h00, data_in};
      for (int i = 0; i < 8; i++) begin
         if (crc_v[0]) begin
            crc_v = (crc_v >> 1) ^ CRC_POLY;
         end else begin
            crc_v = crc_v >> 1;
         end
      end
      crc_out = crc_v;
   end

endmodule
`endif

// File: rtl/usb_tx_seq.sv
// usb_tx_seq: USB transmit sequencer. Passes a payload byte stream from a
// valid/ready input to a registered valid/ready transmit port and keeps a
// history of accepted transmit beats. With USB_TX_CRC_EN defined, two
// inverted CRC16 bytes (low byte first) are appended to every packet.
module usb_tx_seq
   import usb_tx_pkg::*;
#(
   parameter int MAX_LEN    = 64,
   parameter int HIST_DEPTH = 10,
   localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  send_data,
   input  logic [LEN_W-1:0]      len,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  tx_last,
   output logic                  busy,
   output logic [HIST_DEPTH-1:0] hist
);

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_e                state_q, state_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [LEN_W-1:0]      count_q, count_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  tx_last_q, tx_last_d;
   logic [HIST_DEPTH-1:0] hist_q, hist_d;
   logic                  slot_free;
   logic                  in_fire;
   logic                  last_byte;

`ifdef USB_TX_CRC_EN
   logic [15:0] crc_q, crc_d, crc_next;

   usb_crc16_byte u_crc (
      .crc_in  (crc_q),
      .data_in (in_data),
      .crc_out (crc_next)
   );
`endif

   // The output register can take a new byte when empty or being drained now
   assign slot_free = !tx_valid_q || tx_ready;
   assign in_ready  = (state_q == DATA) && slot_free;
   assign in_fire   = in_valid && in_ready;
   assign last_byte = (count_q == (len_q - LEN_ONE));

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign tx_last  = tx_last_q;
   assign hist     = hist_q;
   assign busy     = (state_q != IDLE) || tx_valid_q;

   // Next-state and output-slot logic; the slot only changes when it is free
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      count_d    = count_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      tx_last_d  = tx_last_q;
      hist_d     = {hist_q[HIST_DEPTH-2:0], tx_valid_q && tx_ready};
`ifdef USB_TX_CRC_EN
      crc_d      = crc_q;
`endif

      if (slot_free) begin
         tx_valid_d = 1'b0;
         tx_last_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (send_data) begin
               len_d   = len;
               count_d = '0;
`ifdef USB_TX_CRC_EN
               crc_d   = CRC_INIT;
`endif
               if (len != '0) begin
                  state_d = DATA;
               end else begin
`ifdef USB_TX_CRC_EN
                  state_d = CRC1;
`else
                  state_d = IDLE;
`endif
               end
            end
         end

         DATA: begin
            if (in_fire) begin
               tx_data_d  = in_data;
               tx_valid_d = 1'b1;
               count_d    = count_q + LEN_ONE;
`ifdef USB_TX_CRC_EN
               crc_d      = crc_next;
               if (last_byte) begin
                  state_d = CRC1;
               end
`else
               if (last_byte) begin
                  tx_last_d = 1'b1;
                  state_d   = DRAIN;
               end
`endif
            end
         end

`ifdef USB_TX_CRC_EN
         CRC1: begin
            if (slot_free) begin
               tx_data_d  = ~crc_q[7:0];
               tx_valid_d = 1'b1;
               state_d    = CRC2;
            end
         end

         CRC2: begin
            if (slot_free) begin
               tx_data_d  = ~crc_q[15:8];
               tx_valid_d = 1'b1;
               tx_last_d  = 1'b1;
               state_d    = DRAIN;
            end
         end
`endif

         DRAIN: begin
            if (tx_valid_q && tx_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any partial packet at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         count_q    <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
         hist_q     <= '0;
`ifdef USB_TX_CRC_EN
         crc_q      <= CRC_INIT;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         count_q    <= count_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         tx_last_q  <= tx_last_d;
         hist_q     <= hist_d;
`ifdef USB_TX_CRC_EN
         crc_q      <= crc_d;
`endif
      end
   end

endmodule

// File: tb/tb_usb_tx_seq.sv
// tb_usb_tx_seq: directed bench for usb_tx_seq. Expected beats carry
// {last, data}; CRC expectations apply when USB_TX_CRC_EN is defined.
module tb_usb_tx_seq;

   logic       clk;
   logic       reset;
   logic       sendData;
   logic [6:0] len;
   logic [7:0] inData;
   logic       inValid;
   logic       inReady;
   logic [7:0] txData;
   logic       txValid;
   logic       txReady;
   logic       txLast;
   logic       busy;
   logic [9:0] hist;

   int total = 0;
   int bad   = 0;
   int cycle = 0;
   int startCycle;
   int doneCycle;

   logic [7:0] pay [0:63];
   logic [8:0] expQ[$];
   logic [8:0] gotQ[$];
   int         gotCycle[$];
   logic [9:0] histModel;
   logic       prevStall;
   logic [7:0] prevData;
   logic       prevLast;
   logic       inReadySeen;

   usb_tx_seq #(
      .MAX_LEN    (64),
      .HIST_DEPTH (10)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .send_data (sendData),
      .len       (len),
      .in_data   (inData),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .tx_data   (txData),
      .tx_valid  (txValid),
      .tx_ready  (txReady),
      .tx_last   (txLast),
      .busy      (busy),
      .hist      (hist)
   );

   // Free-running clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // Reference CRC, bit-serial over the payload, returned already inverted
   function automatic logic [15:0] crcModel(input int n);
      logic [15:0] c;
      logic        b;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 8; j++) begin
            b = c[0] ^ pay[i][j];
            c = c >> 1;
            if (b) c = c ^ 16'hA001;
         end
      end
      return ~c;
   endfunction

   // Expected beats for an n-byte packet held in pay[]
   task automatic buildExpected(input int n);
      logic [15:0] c;
      expQ.delete();
      for (int i = 0; i < n; i++) begin
`ifdef USB_TX_CRC_EN
         expQ.push_back({1'b0, pay[i]});
`else
         expQ.push_back({(i == n - 1), pay[i]});
`endif
      end
`ifdef USB_TX_CRC_EN
      c = crcModel(n);
      expQ.push_back({1'b0, c[7:0]});
      expQ.push_back({1'b1, c[15:8]});
`endif
   endtask

   // Observe outputs at the falling edge: beats, stall stability, history
   always @(negedge clk) begin
      if (!reset) begin
         histModel = '0;
         prevStall = 1'b0;
      end else begin
         checkOutput("hist", hist, histModel);
         if (prevStall) checkOutput("stall", {txValid, txLast, txData}, {1'b1, prevLast, prevData});
         if (inReady) inReadySeen = 1'b1;
         if (txValid && txReady) begin
            gotQ.push_back({txLast, txData});
            gotCycle.push_back(cycle);
         end
         prevStall = txValid && !txReady;
         prevData  = txData;
         prevLast  = txLast;
         histModel = {histModel[8:0], txValid && txReady};
      end
   end

   // Runs one packet from pay[]; readyMode 0 = tx_ready high, 1 = toggling
   task automatic applyStimulus(input int n, input int readyMode, input bit midSend);
      int idx;
      int budget;
      gotQ.delete();
      gotCycle.delete();
      @(posedge clk); #1;
      sendData = 1'b1;
      len      = n[6:0];
      txReady  = 1'b1;
      @(posedge clk); #1;
      sendData   = 1'b0;
      startCycle = cycle;
      idx    = 0;
      budget = 0;
      while ((idx < n || busy) && budget < 2000) begin
         inValid  = (idx < n);
         inData   = (idx < n) ? pay[idx] : 8'h00;
         txReady  = (readyMode == 0) ? 1'b1 : (budget % 2 == 0);
         sendData = midSend && (budget == 2);
         if (readyMode == 1 && budget == 6) checkOutput("histalt", hist[1] ^ hist[0], 1);
         @(negedge clk);
         if (inValid && inReady) idx++;
         @(posedge clk); #1;
         budget++;
      end
      inValid   = 1'b0;
      sendData  = 1'b0;
      txReady   = 1'b1;
      doneCycle = cycle;
      checkOutput("timeout", (budget < 2000), 1);
   endtask

   // Compare collected beats with expQ, plus cycle timing when ready is held
   task automatic checkPacket(input string name, input bit timed);
      int last;
      checkOutput({name, ".count"}, gotQ.size(), expQ.size());
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
         checkOutput($sformatf("%s.beat%0d", name, i), gotQ[i], expQ[i]);
      end
      if (timed && gotQ.size() > 0) begin
         last = gotQ.size() - 1;
         checkOutput({name, ".span"}, gotCycle[last] - gotCycle[0] + 1, gotQ.size());
         checkOutput({name, ".lat"}, gotCycle[0] - startCycle, 1);
         checkOutput({name, ".busyfall"}, doneCycle - gotCycle[last], 1);
      end
   endtask

   // Directed sequence
   initial begin
      reset       = 1'b0;
      sendData    = 1'b0;
      len         = '0;
      inData      = 8'h00;
      inValid     = 1'b0;
      txReady     = 1'b1;
      inReadySeen = 1'b0;
      histModel   = '0;
      prevStall   = 1'b0;

      #3;
      checkOutput("rst.valid", txValid, 0);
      checkOutput("rst.last", txLast, 0);
      checkOutput("rst.data", txData, 0);
      checkOutput("rst.inready", inReady, 0);
      checkOutput("rst.busy", busy, 0);
      checkOutput("rst.hist", hist, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Single 0x00 byte
      pay[0] = 8'h00;
      expQ.delete();
`ifdef USB_TX_CRC_EN
      expQ.push_back(9'h000);
      expQ.push_back(9'h040);
      expQ.push_back(9'h1BF);
`else
      expQ.push_back(9'h100);
`endif
      applyStimulus(1, 0, 1'b0);
      checkPacket("zero1", 1'b1);

      // Empty packet; in_ready must stay low throughout
      inReadySeen = 1'b0;
      expQ.delete();
`ifdef USB_TX_CRC_EN
      expQ.push_back(9'h000);
      expQ.push_back(9'h100);
`endif
      applyStimulus(0, 0, 1'b0);
      checkPacket("len0", 1'b1);
      checkOutput("len0.inready", inReadySeen, 0);

      // "123456789": CRC-16/USB check value 0xB4C8, low byte first
      for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
      expQ.delete();
      for (int i = 0; i < 9; i++) begin
`ifdef USB_TX_CRC_EN
         expQ.push_back({1'b0, pay[i]});
`else
         expQ.push_back({(i == 8), pay[i]});
`endif
      end
`ifdef USB_TX_CRC_EN
      expQ.push_back(9'h0C8);
      expQ.push_back(9'h1B4);
`endif
      applyStimulus(9, 0, 1'b0);
      checkPacket("check9", 1'b1);

      // Four bytes with tx_ready toggling every cycle
      pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
      buildExpected(4);
      applyStimulus(4, 1, 1'b0);
      checkPacket("toggle4", 1'b0);

      // Three bytes with a stray send_data pulse mid-packet
      pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
      buildExpected(3);
      applyStimulus(3, 0, 1'b1);
      checkPacket("mid3", 1'b1);

      // Maximum length, continuous flow
      for (int i = 0; i < 64; i++) pay[i] = 8'(i * 3 + 7);
      buildExpected(64);
      applyStimulus(64, 0, 1'b0);
      checkPacket("max64", 1'b1);

      // Asynchronous reset while the last queued byte is stalled
      @(posedge clk); #1;
      sendData = 1'b1;
      len      = 7'd2;
      txReady  = 1'b1;
      @(posedge clk); #1;
      sendData = 1'b0;
      inValid  = 1'b1;
      inData   = 8'h11;
      @(posedge clk); #1;
      inData = 8'h22;
      @(posedge clk); #1;
      inValid = 1'b0;
      txReady = 1'b0;
      checkOutput("rstmid.pre.valid", txValid, 1);
      checkOutput("rstmid.pre.hist0", hist[0], 1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rstmid.valid", txValid, 0);
      checkOutput("rstmid.last", txLast, 0);
      checkOutput("rstmid.data", txData, 0);
      checkOutput("rstmid.busy", busy, 0);
      checkOutput("rstmid.hist", hist, 0);
      checkOutput("rstmid.inready", inReady, 0);
      @(posedge clk); #1;
      reset   = 1'b1;
      txReady = 1'b1;

      // Clean packet after the reset
      pay[0] = 8'h00;
      expQ.delete();
`ifdef USB_TX_CRC_EN
      expQ.push_back(9'h000);
      expQ.push_back(9'h040);
      expQ.push_back(9'h1BF);
`else
      expQ.push_back(9'h100);
`endif
      applyStimulus(1, 0, 1'b0);
      checkPacket("postrst", 1'b1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
